// File: rtl/scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard
// Description : Register-result scoreboard. Tracks, per architectural
//               register, whether a write is outstanding and a one-hot row
//               counting down to its bypass/writeback slot.
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard #(
    parameter int NREGS = 32,
    parameter int ROW_W = 5
) (
    input  logic             clock,
    input  logic             reset,

    input  logic [4:0]       iss_rd_a,
    input  logic [4:0]       iss_rd_b,
    output logic             iss_ass_pending_a,
    output logic [ROW_W-1:0] iss_ass_row_a,
    output logic             iss_ass_pending_b,
    output logic [ROW_W-1:0] iss_ass_row_b,

    input  logic [4:0]       id_rd_a,
    input  logic [4:0]       id_rd_b,
    input  logic [4:0]       id_waw_rd,
    output logic             id_ass_pending_a,
    output logic [ROW_W-1:0] id_ass_row_a,
    output logic             id_ass_pending_b,
    output logic [ROW_W-1:0] id_ass_row_b,
    output logic             id_ass_waw_write_pending,
    output logic [ROW_W-1:0] id_ass_waw_write_row,

    input  logic [2:0]       iss_haz_latency,
    output logic [NREGS-1:0] sb_haz_column,

    input  logic             iss_set_valid,
    input  logic [4:0]       iss_set_reg,
    input  logic [2:0]       iss_set_latency,

    input  logic             wb_done_valid,
    input  logic [4:0]       wb_done_reg
);

    localparam logic [2:0] c_max_lat = 3'(ROW_W);

    logic [NREGS-1:0] r_pending;
    logic [ROW_W-1:0] r_row [NREGS];

    logic [ROW_W-1:0] w_set_row;
    logic [ROW_W-1:0] w_haz_sel;
    logic [NREGS-1:0] w_set_hit;
    logic [NREGS-1:0] w_done_hit;

    // Latencies beyond the row width saturate to the top slot.
    always_comb begin
        w_set_row = '0;
        if (iss_set_latency >= c_max_lat) begin
            w_set_row = {1'b1, {(ROW_W-1){1'b0}}};
        end else if (iss_set_latency != 3'd0) begin
            w_set_row = ROW_W'(1) << (iss_set_latency - 3'd1);
        end
    end

    always_comb begin
        w_haz_sel = '0;
        if (iss_haz_latency != 3'd0 && iss_haz_latency < c_max_lat) begin
            w_haz_sel = ROW_W'(1) << iss_haz_latency;
        end
    end

    always_comb begin
        w_set_hit  = '0;
        w_done_hit = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_set_hit[r]  = iss_set_valid && (iss_set_reg == 5'(r));
            w_done_hit[r] = wb_done_valid && (wb_done_reg == 5'(r));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
            for (int r = 0; r < NREGS; r++) begin
                r_row[r] <= '0;
            end
        end else begin
            r_pending[0] <= 1'b0;
            r_row[0]     <= '0;
            for (int r = 1; r < NREGS; r++) begin
                if (w_set_hit[r]) begin
                    r_pending[r] <= 1'b1;
                    r_row[r]     <= w_set_row;
                end else begin
                    r_row[r] <= r_row[r] >> 1;
                    if (w_done_hit[r] || (r_row[r] == ROW_W'(1))) begin
                        r_pending[r] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        sb_haz_column = '0;
        for (int r = 1; r < NREGS; r++) begin
            sb_haz_column[r] = |(r_row[r] & w_haz_sel);
        end
    end

    // Register 0 reads as never pending regardless of stored state.
    assign iss_ass_pending_a        = (iss_rd_a  != 5'd0) && r_pending[iss_rd_a];
    assign iss_ass_row_a            = (iss_rd_a  != 5'd0) ? r_row[iss_rd_a]  : '0;
    assign iss_ass_pending_b        = (iss_rd_b  != 5'd0) && r_pending[iss_rd_b];
    assign iss_ass_row_b            = (iss_rd_b  != 5'd0) ? r_row[iss_rd_b]  : '0;
    assign id_ass_pending_a         = (id_rd_a   != 5'd0) && r_pending[id_rd_a];
    assign id_ass_row_a             = (id_rd_a   != 5'd0) ? r_row[id_rd_a]   : '0;
    assign id_ass_pending_b         = (id_rd_b   != 5'd0) && r_pending[id_rd_b];
    assign id_ass_row_b             = (id_rd_b   != 5'd0) ? r_row[id_rd_b]   : '0;
    assign id_ass_waw_write_pending = (id_waw_rd != 5'd0) && r_pending[id_waw_rd];
    assign id_ass_waw_write_row     = (id_waw_rd != 5'd0) ? r_row[id_waw_rd] : '0;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_scoreboard
// Description : Randomised and directed bench for scoreboard with a
//               time-based reference model and queue-decoupled checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  iss_rd_a, iss_rd_b, id_rd_a, id_rd_b, id_waw_rd;
    logic        iss_ass_pending_a, iss_ass_pending_b;
    logic [4:0]  iss_ass_row_a, iss_ass_row_b;
    logic        id_ass_pending_a, id_ass_pending_b, id_ass_waw_write_pending;
    logic [4:0]  id_ass_row_a, id_ass_row_b, id_ass_waw_write_row;
    logic [2:0]  iss_haz_latency;
    logic [31:0] sb_haz_column;
    logic        iss_set_valid;
    logic [4:0]  iss_set_reg;
    logic [2:0]  iss_set_latency;
    logic        wb_done_valid;
    logic [4:0]  wb_done_reg;

    always #5 clock = ~clock;

    scoreboard #(.NREGS(32), .ROW_W(5)) dut (
        .clock(clock), .reset(reset),
        .iss_rd_a(iss_rd_a), .iss_rd_b(iss_rd_b),
        .iss_ass_pending_a(iss_ass_pending_a), .iss_ass_row_a(iss_ass_row_a),
        .iss_ass_pending_b(iss_ass_pending_b), .iss_ass_row_b(iss_ass_row_b),
        .id_rd_a(id_rd_a), .id_rd_b(id_rd_b), .id_waw_rd(id_waw_rd),
        .id_ass_pending_a(id_ass_pending_a), .id_ass_row_a(id_ass_row_a),
        .id_ass_pending_b(id_ass_pending_b), .id_ass_row_b(id_ass_row_b),
        .id_ass_waw_write_pending(id_ass_waw_write_pending),
        .id_ass_waw_write_row(id_ass_waw_write_row),
        .iss_haz_latency(iss_haz_latency), .sb_haz_column(sb_haz_column),
        .iss_set_valid(iss_set_valid), .iss_set_reg(iss_set_reg),
        .iss_set_latency(iss_set_latency),
        .wb_done_valid(wb_done_valid), .wb_done_reg(wb_done_reg)
    );

    typedef struct {
        logic       reset;
        logic [4:0] rd_a, rd_b, id_a, id_b, waw;
        logic [2:0] haz;
        logic       set_v;
        logic [4:0] set_reg;
        logic [2:0] set_lat;
        logic       done_v;
        logic [4:0] done_reg;
    } stim_t;

    typedef struct {
        int          cyc;
        logic        pa, pb, ipa, ipb, wp;
        logic [4:0]  ra, rb, ira, irb, wr;
        logic [31:0] col;
    } exp_t;

    // Model: each register has a pending flag and the absolute cycle at
    // which its fixed-latency result reaches the bypass (NONE if variable).
    localparam int NONE = -1000;
    bit   m_pend  [32];
    int   m_ready [32];
    int   cyc;
    exp_t q[$];
    int   n_vec;
    int   n_bad;

    function automatic logic e_pend(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r];
    endfunction

    function automatic logic [4:0] e_row(input logic [4:0] r);
        int d;
        if (r == 5'd0) return 5'd0;
        d = m_ready[r] - cyc;
        if (d >= 0 && d < 5) return 5'(1 << d);
        return 5'd0;
    endfunction

    function automatic logic [31:0] e_col(input logic [2:0] l);
        logic [31:0] c;
        c = '0;
        if (l >= 3'd1 && l <= 3'd4) begin
            for (int r = 1; r < 32; r++) begin
                if (m_ready[r] - cyc == int'(l)) c[r] = 1'b1;
            end
        end
        return c;
    endfunction

    function automatic void model_update(input stim_t s);
        for (int r = 1; r < 32; r++) begin
            if (s.reset) begin
                m_pend[r]  = 1'b0;
                m_ready[r] = NONE;
            end else if (s.set_v && s.set_reg == 5'(r)) begin
                m_pend[r]  = 1'b1;
                m_ready[r] = (s.set_lat == 3'd0) ? NONE
                           : cyc + ((s.set_lat > 3'd5) ? 5 : int'(s.set_lat));
            end else begin
                if (s.done_v && s.done_reg == 5'(r)) m_pend[r] = 1'b0;
                if (m_ready[r] == cyc) m_pend[r] = 1'b0;
            end
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.reset    = 1'b0;
        s.rd_a     = 5'($urandom_range(0, 31));
        s.rd_b     = 5'($urandom_range(0, 31));
        s.id_a     = 5'($urandom_range(0, 31));
        s.id_b     = 5'($urandom_range(0, 31));
        s.waw      = 5'($urandom_range(0, 31));
        s.haz      = 3'($urandom_range(0, 7));
        s.set_v    = 1'b0;
        s.set_reg  = 5'd0;
        s.set_lat  = 3'd0;
        s.done_v   = 1'b0;
        s.done_reg = 5'd0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        reset           = s.reset;
        iss_rd_a        = s.rd_a;
        iss_rd_b        = s.rd_b;
        id_rd_a         = s.id_a;
        id_rd_b         = s.id_b;
        id_waw_rd       = s.waw;
        iss_haz_latency = s.haz;
        iss_set_valid   = s.set_v;
        iss_set_reg     = s.set_reg;
        iss_set_latency = s.set_lat;
        wb_done_valid   = s.done_v;
        wb_done_reg     = s.done_reg;
    endtask

    // Called just after a rising edge: apply inputs, queue the expected
    // outputs for this cycle, then advance the model across the next edge.
    task automatic step(input stim_t s);
        exp_t e;
        drive(s);
        e.cyc = cyc;
        e.pa  = e_pend(s.rd_a);  e.ra  = e_row(s.rd_a);
        e.pb  = e_pend(s.rd_b);  e.rb  = e_row(s.rd_b);
        e.ipa = e_pend(s.id_a);  e.ira = e_row(s.id_a);
        e.ipb = e_pend(s.id_b);  e.irb = e_row(s.id_b);
        e.wp  = e_pend(s.waw);   e.wr  = e_row(s.waw);
        e.col = e_col(s.haz);
        q.push_back(e);
        @(posedge clock);
        model_update(s);
        cyc++;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp, input int c);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("iss_pending_a", 32'(iss_ass_pending_a), 32'(e.pa), e.cyc);
                chk("iss_row_a", 32'(iss_ass_row_a), 32'(e.ra), e.cyc);
                chk("iss_pending_b", 32'(iss_ass_pending_b), 32'(e.pb), e.cyc);
                chk("iss_row_b", 32'(iss_ass_row_b), 32'(e.rb), e.cyc);
                chk("id_pending_a", 32'(id_ass_pending_a), 32'(e.ipa), e.cyc);
                chk("id_row_a", 32'(id_ass_row_a), 32'(e.ira), e.cyc);
                chk("id_pending_b", 32'(id_ass_pending_b), 32'(e.ipb), e.cyc);
                chk("id_row_b", 32'(id_ass_row_b), 32'(e.irb), e.cyc);
                chk("waw_pending", 32'(id_ass_waw_write_pending), 32'(e.wp), e.cyc);
                chk("waw_row", 32'(id_ass_waw_write_row), 32'(e.wr), e.cyc);
                chk("haz_column", sb_haz_column, e.col, e.cyc);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        for (int r = 0; r < 32; r++) begin
            m_pend[r]  = 1'b0;
            m_ready[r] = NONE;
        end
        s = idle();
        s.reset = 1'b1;
        drive(s);
        repeat (2) @(posedge clock);
        #1;

        // Every register reads clear after reset.
        for (int i = 0; i < 32; i++) begin
            s = idle();
            s.rd_a = 5'(i); s.rd_b = 5'(31 - i); s.id_a = 5'(i);
            s.id_b = 5'(i); s.waw = 5'(i); s.haz = 3'(i % 8);
            step(s);
        end

        // Fixed latency 3 countdown on register 5.
        s = idle(); s.rd_a = 5'd5;
        s.set_v = 1'b1; s.set_reg = 5'd5; s.set_lat = 3'd3;
        step(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.rd_a = 5'd5; s.waw = 5'd5;
            step(s);
        end

        // Variable latency on register 7 completes six cycles later.
        s = idle(); s.rd_a = 5'd7;
        s.set_v = 1'b1; s.set_reg = 5'd7; s.set_lat = 3'd0;
        step(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.rd_a = 5'd7;
            step(s);
        end
        s = idle(); s.rd_a = 5'd7; s.done_v = 1'b1; s.done_reg = 5'd7;
        step(s);
        for (int i = 0; i < 2; i++) begin
            s = idle(); s.rd_a = 5'd7;
            step(s);
        end

        // Writeback-slot column for register 9 at latency 4.
        s = idle(); s.set_v = 1'b1; s.set_reg = 5'd9; s.set_lat = 3'd4;
        step(s);
        s = idle(); s.rd_a = 5'd9; s.haz = 3'd3;
        s.set_v = 1'b1; s.set_reg = 5'd9; s.set_lat = 3'd4;
        step(s);
        s = idle(); s.rd_a = 5'd9; s.haz = 3'd2;
        step(s);
        for (int l = 0; l < 8; l++) begin
            s = idle(); s.haz = 3'(l); s.set_v = 1'b1; s.set_reg = 5'd12;
            s.set_lat = 3'(l); s.rd_a = 5'd12;
            step(s);
        end

        // Set beats done on the same register in the same cycle.
        s = idle(); s.set_v = 1'b1; s.set_reg = 5'd4; s.set_lat = 3'd0;
        step(s);
        s = idle(); s.rd_a = 5'd4;
        step(s);
        s = idle(); s.rd_a = 5'd4;
        s.set_v = 1'b1; s.set_reg = 5'd4; s.set_lat = 3'd2;
        s.done_v = 1'b1; s.done_reg = 5'd4;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rd_a = 5'd4;
            step(s);
        end

        // Register 0 writes, index 0 reads, and reset discarding pending state.
        s = idle(); s.rd_a = 5'd0; s.rd_b = 5'd0; s.id_a = 5'd0;
        s.id_b = 5'd0; s.waw = 5'd0;
        s.set_v = 1'b1; s.set_reg = 5'd0; s.set_lat = 3'd1;
        step(s);
        s = idle(); s.rd_a = 5'd0; s.waw = 5'd0; s.haz = 3'd1;
        s.set_v = 1'b1; s.set_reg = 5'd3; s.set_lat = 3'd0;
        step(s);
        s = idle(); s.rd_a = 5'd3; s.reset = 1'b1;
        s.set_v = 1'b1; s.set_reg = 5'd3; s.set_lat = 3'd2;
        s.done_v = 1'b1; s.done_reg = 5'd3;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rd_a = 5'd3;
            step(s);
        end

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            s = idle();
            s.reset    = ($urandom_range(0, 199) == 0);
            s.set_v    = ($urandom_range(0, 2) == 0);
            s.set_reg  = 5'($urandom_range(0, 31));
            s.set_lat  = 3'($urandom_range(0, 7));
            s.done_v   = ($urandom_range(0, 2) == 0);
            s.done_reg = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) s.rd_a = s.set_reg;
            step(s);
        end

        repeat (2) @(negedge clock);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- Register-result scoreboard: tracks, per architectural register, whether a write is outstanding and in how many cycles it reaches the bypass/writeback point.
- Supplies the pending bits, 5-bit timing rows and writeback-slot hazard column consumed by the Issue-stage and Decode-stage hazard checks.
- Updated by Issue (new destination writes) and by the variable-latency completion port (loads, mult/div).

Parameters:
- NREGS, 32, number of architectural registers (register 0 hard-wired zero).
- ROW_W, 5, width of each timing row (maximum fixed latency).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- iss_rd_a  input  5  Issue read-port A register index
- iss_rd_b  input  5  Issue read-port B register index
- iss_ass_pending_a  output  1  pending bit for iss_rd_a
- iss_ass_row_a  output  5  timing row for iss_rd_a
- iss_ass_pending_b  output  1  pending bit for iss_rd_b
- iss_ass_row_b  output  5  timing row for iss_rd_b
- id_rd_a  input  5  Decode read-port A register index
- id_rd_b  input  5  Decode read-port B register index
- id_waw_rd  input  5  Decode destination register index (WAW check)
- id_ass_pending_a / id_ass_row_a  output  1 / 5  status for id_rd_a
- id_ass_pending_b / id_ass_row_b  output  1 / 5  status for id_rd_b
- id_ass_waw_write_pending / id_ass_waw_write_row  output  1 / 5  status for id_waw_rd
- iss_haz_latency  input  3  latency of the instruction currently in Issue
- sb_haz_column  output  32  bit r = register r writes back in the same slot
- iss_set_valid  input  1  Issue accepts an instruction that writes a register
- iss_set_reg  input  5  destination register
- iss_set_latency  input  3  0 = variable latency; 1..5 = fixed; 6, 7 treated as 5
- wb_done_valid  input  1  variable-latency result completes this cycle
- wb_done_reg  input  5  register completed

Behaviour:
- State per register r: pending[r] (1 bit) and row[r] (ROW_W bits, one-hot or zero).
- row[r] bit k set at cycle c means the result is on the bypass at cycle c+k; bit 0 means available this cycle.
- Reset (synchronous): all pending and row bits cleared, so every output reads 0 the cycle after reset is sampled.
- Reset mid-operation discards all in-flight tracking; iss_set and wb_done in that cycle are ignored.
- Read ports are combinational from current state with no same-cycle forwarding of set or done. Index 0 always returns pending=0, row=0.
- Every cycle, every row shifts right by one, with zero filled in at the top.
- Clear on fixed latency: if row[r]==00001, pending[r] clears next cycle.
- Clear on variable latency: wb_done_valid with wb_done_reg=r clears pending[r] next cycle; row[r] is unaffected.
- Issue set (iss_set_valid, reg r != 0, latency L):
  - Next cycle pending[r]=1.
  - row[r] = 1<<(L-1) for L in 1..5 (6, 7 clamp to 5).
  - row[r] = 0 for L=0, which stays pending until wb_done.
- Simultaneous events on the same register: set wins over the shift, over the row-zero clear, and over wb_done (pending=1, new row).
- Writes to register 0 are ignored.
- wb_done for a register with no pending entry has no effect.
- sb_haz_column is combinational. For iss_haz_latency L in 1..4, bit r = row[r][L]. For L=0, or L>=5, the column is 0, because no existing entry can occupy that slot.
- Bit 0 of sb_haz_column is always 0.
- Fixed-latency issue-to-bypass: an instruction issued at t with latency L shows row bit 0 exactly at t+L.

Test Plan:
- Reset then read all registers -> every pending, row and sb_haz_column output is 0.
- iss_set reg 5, L=3 at cycle t -> rows: t+1 00100, t+2 00010, t+3 00001 (pending 1 throughout); t+4 pending 0, row 00000.
- iss_set reg 7, L=0 at t; wb_done reg 7 at t+6 -> pending 1, row 0 over t+1..t+6; pending 0 from t+7.
- iss_set reg 9, L=4 at t; at t+1 drive iss_haz_latency=3 -> sb_haz_column = 0x00000200; with iss_haz_latency=2 -> column 0.
- Same cycle: iss_set reg 4, L=2 and wb_done reg 4 while reg 4 is variable-pending -> next cycle pending 1, row 00010.
- iss_set reg 0, L=1, and reads of index 0 -> all outputs 0; assert reset while reg 3 is pending -> reg 3 is clear the next cycle.
